avalon_mem_tester_master: RTL
=============================

Name: avalon_mem_tester_master

Overview:
- Avalon-MM master that drives a single-port on-chip RAM slave (32-bit data, 13-bit word address, 4-bit byteenable, fixed read latency).
- On a start command it writes a deterministic pattern over a word range, then reads the range back with pipelined reads and compares each word.
- Reports done, error count and first failing address/data.
- Used for bring-up self-test and RAM initialisation ahead of the Nios II boot.

Parameters:
- ADDR_W, 13, word address width; addresses wrap mod 2^ADDR_W.
- DATA_W, 32, data width; fixed at 32 (byteenable is 4 bits).
- READ_LATENCY, 1, cycles from an accepted read to valid avm_readdata; legal range 1..4.
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- mode  in  2  sampled with start: 0 = write+verify, 1 = write only, 2 = verify only, 3 = reserved (treated as 0)
- base_addr  in  ADDR_W  first word address
- word_count  in  ADDR_W+1  number of words, 0..2^ADDR_W
- seed  in  32  pattern seed
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- err_count  out  ERR_W  mismatches in the last run; saturates at all-ones
- first_err_addr  out  ADDR_W  address of the first mismatch
- first_err_data  out  32  readdata of the first mismatch
- avm_address  out  ADDR_W  word address
- avm_byteenable  out  4  always 4'hF while avm_write or avm_read is asserted; 0 otherwise
- avm_chipselect  out  1  asserted with avm_write or avm_read
- avm_write  out  1  write request
- avm_read  out  1  read request
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data, valid READ_LATENCY cycles after an accepted read
- avm_waitrequest  in  1  slave stall; tie low for the on-chip RAM

Behaviour:
- Reset: all outputs 0 (err_count, first_err_addr and first_err_data included); FSM returns to IDLE; outstanding-read pipeline cleared. Reset asserted mid-run aborts the run; no done pulse is issued.
- Pattern: expected(i) = seed + i*32'h01010101 (mod 2^32), where i is the word index 0..word_count-1. Address(i) = (base_addr + i) mod 2^ADDR_W.
- FSM states: IDLE, WRITE, READ, DRAIN, FINISH.
- IDLE:
  - start latches mode, base, count and seed; clears err_count and first_err_*.
  - Next state: WRITE, or READ if mode = 2.
  - If word_count = 0: go straight to FINISH, with no bus cycles.
  - start while not IDLE is ignored.
- WRITE:
  - Asserts avm_write, avm_chipselect and avm_byteenable = F, with address(i) and expected(i).
  - Transfer is accepted on a cycle with avm_waitrequest = 0; i then increments.
  - Address, data and control are held stable while waitrequest = 1.
  - After the last accepted write: go to READ (mode 0) or FINISH (mode 1).
  - One write per cycle at zero wait states.
- READ:
  - Asserts avm_read and avm_chipselect with address(i); i restarts at 0 on entry.
  - Each accepted read pushes {valid, i} into a READ_LATENCY-deep shift register.
  - After the last accepted read: go to DRAIN.
  - No bubble between the last write and the first read.
- Compare:
  - When a shift-register entry reaches the output, compare avm_readdata with expected(index).
  - On mismatch, err_count increments (saturating). If err_count was 0, capture first_err_addr and first_err_data.
- DRAIN: waits until the shift register is empty, then goes to FINISH.
- FINISH: done = 1 for exactly one cycle, busy = 0 in the same cycle, then IDLE. A start in the FINISH cycle is ignored.
- busy is high in WRITE, READ and DRAIN.
- avm_write and avm_read are never asserted together.

Test Plan:
- Write+verify, no errors: base 0x0100, count 4, seed 0x11223344, waitrequest = 0. Required: writes of 0x11223344, 0x12233445, 0x13243546, 0x14253647 at 0x100..0x103; 4 reads; done 11 cycles after start with READ_LATENCY = 1; err_count = 0.
- Injected error: RAM model flips bit 0 of word 0x102. Required: err_count = 1, first_err_addr = 0x102, first_err_data = 0x13243547.
- Wrap and waitrequest: base 0x1FFE, count 4, waitrequest asserted on every other cycle. Required: addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001; each request held stable until accepted; err_count = 0.
- Edge counts: count 0 gives done one cycle after start with no bus activity. count 8192 gives 8192 writes and 8192 reads.
- READ_LATENCY = 3, mode 2 on a fully corrupted RAM, count 20. Required: err_count = 20; first_err_addr = base.
- Reset mid-WRITE: pulse reset on the 3rd write. Required: all outputs 0 on the next cycle; no done pulse. A subsequent start runs normally.

Source files
------------

// File: rtl/avalon_mem_tester_master.sv
// Avalon-MM memory tester: writes a seeded arithmetic pattern over a word range,
// reads it back with pipelined reads and reports mismatch statistics.
module avalon_mem_tester_master #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   word_count_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic [DATA_W-1:0] first_err_data_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic [3:0]        avm_byteenable_o,
    output logic              avm_chipselect_o,
    output logic              avm_write_o,
    output logic              avm_read_o,
    output logic [DATA_W-1:0] avm_writedata_o,
    input  logic [DATA_W-1:0] avm_readdata_i,
    input  logic              avm_waitrequest_i
);

    localparam logic [DATA_W-1:0] PAT_STEP = 32'h0101_0101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]   ferr_addr_q, ferr_addr_d;
    logic [DATA_W-1:0]   ferr_data_q, ferr_data_d;

    logic [READ_LATENCY-1:0] pv_q;
    logic [ADDR_W-1:0]       paddr_q [READ_LATENCY];
    logic [DATA_W-1:0]       pexp_q  [READ_LATENCY];

    logic accept_s;
    logic last_s;
    logic push_s;
    logic mismatch_s;

    assign accept_s   = !avm_waitrequest_i;
    assign last_s     = (idx_q == (count_q - (ADDR_W+1)'(1)));
    assign mismatch_s = pv_q[READ_LATENCY-1] &&
                        (avm_readdata_i != pexp_q[READ_LATENCY-1]);

    // Next-state, address/pattern sequencing and mismatch accounting.
    always_comb begin
        state_d     = state_q;
        rd_en_d     = rd_en_q;
        base_d      = base_q;
        count_d     = count_q;
        seed_d      = seed_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        pat_d       = pat_q;
        err_d       = err_q;
        ferr_addr_d = ferr_addr_q;
        ferr_data_d = ferr_data_q;
        push_s      = 1'b0;

        if (mismatch_s) begin
            if (err_q != {ERR_W{1'b1}}) begin
                err_d = err_q + ERR_W'(1);
            end else begin
                err_d = err_q;
            end
            if (err_q == {ERR_W{1'b0}}) begin
                ferr_addr_d = paddr_q[READ_LATENCY-1];
                ferr_data_d = avm_readdata_i;
            end else begin
                ferr_addr_d = ferr_addr_q;
                ferr_data_d = ferr_data_q;
            end
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    rd_en_d     = (mode_i != 2'd1);
                    base_d      = base_addr_i;
                    count_d     = word_count_i;
                    seed_d      = seed_i;
                    idx_d       = {(ADDR_W+1){1'b0}};
                    addr_d      = base_addr_i;
                    pat_d       = seed_i;
                    err_d       = {ERR_W{1'b0}};
                    ferr_addr_d = {ADDR_W{1'b0}};
                    ferr_data_d = {DATA_W{1'b0}};
                    if (word_count_i == {(ADDR_W+1){1'b0}}) begin
                        state_d = ST_FINISH;
                    end else if (mode_i == 2'd2) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (accept_s && last_s) begin
                    // Rewind straight into the read pass so there is no bubble.
                    idx_d   = {(ADDR_W+1){1'b0}};
                    addr_d  = base_q;
                    pat_d   = seed_q;
                    state_d = rd_en_q ? ST_READ : ST_FINISH;
                end else if (accept_s) begin
                    idx_d  = idx_q + (ADDR_W+1)'(1);
                    addr_d = addr_q + ADDR_W'(1);
                    pat_d  = pat_q + PAT_STEP;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                push_s = accept_s;
                if (accept_s && last_s) begin
                    state_d = ST_DRAIN;
                end else if (accept_s) begin
                    idx_d  = idx_q + (ADDR_W+1)'(1);
                    addr_d = addr_q + ADDR_W'(1);
                    pat_d  = pat_q + PAT_STEP;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (pv_q == {READ_LATENCY{1'b0}}) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            rd_en_q     <= 1'b0;
            base_q      <= {ADDR_W{1'b0}};
            count_q     <= {(ADDR_W+1){1'b0}};
            seed_q      <= {DATA_W{1'b0}};
            idx_q       <= {(ADDR_W+1){1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            pat_q       <= {DATA_W{1'b0}};
            err_q       <= {ERR_W{1'b0}};
            ferr_addr_q <= {ADDR_W{1'b0}};
            ferr_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            base_q      <= base_d;
            count_q     <= count_d;
            seed_q      <= seed_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            pat_q       <= pat_d;
            err_q       <= err_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_data_q <= ferr_data_d;
        end
    end

    // Tag pipeline: carries address and expected data alongside each accepted read.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pv_q <= {READ_LATENCY{1'b0}};
            for (int i = 0; i < READ_LATENCY; i++) begin
                paddr_q[i] <= {ADDR_W{1'b0}};
                pexp_q[i]  <= {DATA_W{1'b0}};
            end
        end else begin
            pv_q[0]    <= push_s;
            paddr_q[0] <= addr_q;
            pexp_q[0]  <= pat_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_q[i]    <= pv_q[i-1];
                paddr_q[i] <= paddr_q[i-1];
                pexp_q[i]  <= pexp_q[i-1];
            end
        end
    end

    assign busy_o           = (state_q == ST_WRITE) || (state_q == ST_READ) ||
                              (state_q == ST_DRAIN);
    assign done_o           = (state_q == ST_FINISH);
    assign err_count_o      = err_q;
    assign first_err_addr_o = ferr_addr_q;
    assign first_err_data_o = ferr_data_q;
    assign avm_write_o      = (state_q == ST_WRITE);
    assign avm_read_o       = (state_q == ST_READ);
    assign avm_chipselect_o = avm_write_o | avm_read_o;
    assign avm_byteenable_o = avm_chipselect_o ? 4'hF : 4'h0;
    assign avm_address_o    = addr_q;
    assign avm_writedata_o  = avm_write_o ? pat_q : {DATA_W{1'b0}};

endmodule
